sbox_v2: RTL and testbench
==========================

// Module: sbox_v2
// PURPOSE
//  AES forward S-box (SubBytes) for one byte, computed with composite-field GF((2^4)^2) arithmetic, not a ROM.
//  Sits in the AES round datapath and the key-expansion SubWord path; instantiate once per byte lane.
//  Combinational datapath with a registered output: one result per clock, 1-cycle latency.
// PARAMETERS
//  none (the datapath is fixed to 8 bits)
// PORTS
//  clk        in   1  single clock; all state updates on rising edge
//  rst        in   1  asynchronous reset, active-high
//  in_valid   in   1  in_byte is valid this cycle
//  in_byte    in   8  byte to substitute
//  out_valid  out  1  out_byte is valid; in_valid delayed by 1 cycle
//  out_byte   out  8  S(in_byte), registered
// BEHAVIOUR
//  - Reset (async, rst=1): out_byte=8'h00 and out_valid=0 immediately; both held while rst=1.
//  - Each rising edge with rst=0:
//    - out_valid <= in_valid.
//    - out_byte <= S(in_byte) when in_valid=1; otherwise it holds its previous value.
//    - Back-to-back inputs are accepted every cycle; no stall or backpressure.
//  - Result must equal the FIPS-197 S-box for all 256 inputs.
//  - Datapath, with a = in_byte and ^ = XOR:
//    1) Isomorphism to q = {g1,g0}:
//       q7=a5^a7; q6=a1^a4^a5^a6; q5=a2^a3^a5^a7; q4=a2^a3^a4^a6^a7
//       q3=a1^a2^a6^a7; q2=a2^a3^a6^a7; q1=a1^a4^a6; q0=a0^a1^a2^a3^a7
//    2) GF(16) uses polynomial x^4+x+1: a shift-left with carry out of bit 3 XORs in 4'b0011.
//       - mul: shift-and-add over the bits of b.
//       - sq(x) = {x3, x1^x3, x2, x0^x2}.
//       - sqv(x) = mul(sq(x), 4'hD).
//       - inv: multiplicative inverse in GF(16), with inv(0)=0; implement as a 16-entry case or sum-of-products.
//    3) t = mul(g1,g0) ^ sq(g0) ^ sqv(g1); i = inv(t); d1 = mul(g1,i); d0 = mul(g0^g1,i).
//    4) Inverse isomorphism plus affine step on d = {d1,d0}:
//       s7=d1^d2^d3^d7; s6=~(d4^d7); s5=~(d1^d2^d7); s4=d0^d1^d2^d4^d6^d7
//       s3=d0; s2=d0^d1^d3^d4; s1=~(d0^d2^d7); s0=~(d0^d5^d6^d7)
//  - Input 0x00: t=0 and inv(0)=0, so the output is the affine constant 0x63. No special-case logic.
//  - Reset asserted mid-stream: the in-flight result is discarded and out_valid=0.
//    The first valid output after reset release appears 1 cycle after the first in_valid.
//  - No X-propagation on outputs after reset; no combinational in->out path.
// STRUCTURE
//  - Shared package aes_gf_pkg holds:
//    - constant GF16_POLY = 4'b0011 and GF16_V = 4'hD;
//    - functions gf16_mul, gf16_sq, gf16_sqv, gf16_inv, aes_iso, aes_inv_iso_affine.
//  - One natural sub-module: sbox_v2_comb, the pure combinational byte->byte datapath (steps 1-4).
//  - sbox_v2 wraps sbox_v2_comb with the output and valid registers.
// TESTING
//  - Reset: rst=1 with inputs toggling -> out_byte=0x00, out_valid=0. After release with in_valid=0 -> out_valid stays 0.
//  - Known vectors, in_valid=1 -> one cycle later:
//    00->63, 01->7C, 10->CA, 53->ED, FF->16, C9->DD.
//  - Exhaustive sweep 0x00..0xFF, one byte per cycle -> every out_byte matches the FIPS-197 table.
//    out_valid is high continuously after the first cycle.
//  - in_valid gap: send 0x01, idle 2 cycles, send 0x53 -> out_byte holds 7C during the idle cycles;
//    out_valid pattern is 1,0,0,1.
//  - Mid-stream reset: assert rst asynchronously between edges while streaming -> outputs clear at once;
//    after release, the next input is back to 1-cycle latency and the result is correct.

Source files
------------

// File: rtl/aes_gf_pkg.sv
// GF(16) and basis-change helpers for a composite-field GF((2^4)^2) AES S-box.
// The field polynomial is x^4+x+1 and the norm constant is v = 4'hD.
package aes_gf_pkg;

   localparam logic [3:0] GF16_POLY = 4'b0011;
   localparam logic [3:0] GF16_V    = 4'hD;

   function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] acc;
      logic [3:0] x;
      acc = 4'h0;
      x   = a;
      for (int k = 0; k < 4; k++) begin
         if (b[k]) acc = acc ^ x;
         x = {x[2:0], 1'b0} ^ (x[3] ? GF16_POLY : 4'h0);
      end
      return acc;
   endfunction

   function automatic logic [3:0] gf16_sq(input logic [3:0] x);
      return {x[3], x[1] ^ x[3], x[2], x[0] ^ x[2]};
   endfunction

   function automatic logic [3:0] gf16_sqv(input logic [3:0] x);
      return gf16_mul(gf16_sq(x), GF16_V);
   endfunction

   // Inverse of zero is mapped to zero so the 0x00 input needs no special handling.
   function automatic logic [3:0] gf16_inv(input logic [3:0] x);
      logic [3:0] r;
      case (x)
         4'h0:    r = 4'h0;
         4'h1:    r = 4'h1;
         4'h2:    r = 4'h9;
         4'h3:    r = 4'hE;
         4'h4:    r = 4'hD;
         4'h5:    r = 4'hB;
         4'h6:    r = 4'h7;
         4'h7:    r = 4'h6;
         4'h8:    r = 4'hF;
         4'h9:    r = 4'h2;
         4'hA:    r = 4'hC;
         4'hB:    r = 4'h5;
         4'hC:    r = 4'hA;
         4'hD:    r = 4'h4;
         4'hE:    r = 4'h3;
         4'hF:    r = 4'h8;
         default: r = 4'h0;
      endcase
      return r;
   endfunction

   function automatic logic [7:0] aes_iso(input logic [7:0] a);
      logic [7:0] q;
      q[7] = a[5] ^ a[7];
      q[6] = a[1] ^ a[4] ^ a[5] ^ a[6];
      q[5] = a[2] ^ a[3] ^ a[5] ^ a[7];
      q[4] = a[2] ^ a[3] ^ a[4] ^ a[6] ^ a[7];
      q[3] = a[1] ^ a[2] ^ a[6] ^ a[7];
      q[2] = a[2] ^ a[3] ^ a[6] ^ a[7];
      q[1] = a[1] ^ a[4] ^ a[6];
      q[0] = a[0] ^ a[1] ^ a[2] ^ a[3] ^ a[7];
      return q;
   endfunction

   // Back to the polynomial basis with the AES affine map (constant 0x63) folded in.
   function automatic logic [7:0] aes_inv_iso_affine(input logic [7:0] d);
      logic [7:0] s;
      s[7] = d[1] ^ d[2] ^ d[3] ^ d[7];
      s[6] = ~(d[4] ^ d[7]);
      s[5] = ~(d[1] ^ d[2] ^ d[7]);
      s[4] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[6] ^ d[7];
      s[3] = d[0];
      s[2] = d[0] ^ d[1] ^ d[3] ^ d[4];
      s[1] = ~(d[0] ^ d[2] ^ d[7]);
      s[0] = ~(d[0] ^ d[5] ^ d[6] ^ d[7]);
      return s;
   endfunction

endpackage

// File: rtl/sbox_v2_comb.sv
// Pure combinational AES forward S-box: basis change, GF(16) inversion of the
// GF(256) element, then inverse basis change with the affine step.
module sbox_v2_comb
   import aes_gf_pkg::*;
(
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);

   logic [7:0] w_q;
   logic [3:0] w_g1;
   logic [3:0] w_g0;
   logic [3:0] w_t;
   logic [3:0] w_i;
   logic [3:0] w_d1;
   logic [3:0] w_d0;

   assign w_q  = aes_iso(i_byte);
   assign w_g1 = w_q[7:4];
   assign w_g0 = w_q[3:0];

   // w_t is the GF(16) norm of {g1,g0}; inverting it yields the GF(256) inverse.
   assign w_t  = gf16_mul(w_g1, w_g0) ^ gf16_sq(w_g0) ^ gf16_sqv(w_g1);
   assign w_i  = gf16_inv(w_t);
   assign w_d1 = gf16_mul(w_g1, w_i);
   assign w_d0 = gf16_mul(w_g0 ^ w_g1, w_i);

   assign o_byte = aes_inv_iso_affine({w_d1, w_d0});

endmodule

// File: rtl/sbox_v2.sv
// One-byte AES SubBytes lane: combinational composite-field S-box with a
// registered result and valid, one result per clock at 1-cycle latency.
module sbox_v2
   import aes_gf_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] in_byte,
   output logic       out_valid,
   output logic [7:0] out_byte
);

   logic [7:0] w_sbox;
   logic       r_out_valid;
   logic [7:0] r_out_byte;

   sbox_v2_comb u_comb (
      .i_byte (in_byte),
      .o_byte (w_sbox)
   );

   // Output byte only updates on a valid input so it holds across idle cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_byte  <= 8'h00;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_out_byte <= w_sbox;
         end else begin
            r_out_byte <= r_out_byte;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_byte  = r_out_byte;

endmodule

// File: tb/tb_sbox_v2.sv
// Scoreboard bench for sbox_v2: the driver queues expected bytes from a GF(2^8)
// inverse + affine reference; a monitor checks every cycle after the clock edge.
module tb_sbox_v2;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_byte;
   logic       out_valid;
   logic [7:0] out_byte;

   int         n_vec  = 0;
   int         n_fail = 0;
   logic [7:0] exp_q[$];
   logic [7:0] held;
   logic       mon_iv;
   logic       mon_rst;

   sbox_v2 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_byte   (in_byte),
      .out_valid (out_valid),
      .out_byte  (out_byte)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] x;
      acc = 8'h00;
      x   = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) acc = acc ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
      end
      return acc;
   endfunction

   function automatic logic [7:0] ref_sbox(input logic [7:0] a);
      logic [7:0] inv;
      logic [7:0] r;
      logic [7:0] s;
      logic [7:0] c8;
      inv = 8'h00;
      for (int c = 1; c < 256; c++) begin
         c8 = c[7:0];
         if (a != 8'h00 && gmul(a, c8) == 8'h01) inv = c8;
      end
      r = inv;
      s = inv;
      for (int k = 0; k < 4; k++) begin
         r = {r[6:0], r[7]};
         s = s ^ r;
      end
      return s ^ 8'h63;
   endfunction

   task automatic check(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %02h, expected %02h at %0t", name, act, req, $time);
      end
   endtask

   task automatic send_exp(input logic v, input logic [7:0] b, input logic [7:0] e);
      @(negedge clk);
      in_valid = v;
      in_byte  = b;
      if (v && !rst) exp_q.push_back(e);
   endtask

   task automatic send(input logic v, input logic [7:0] b);
      send_exp(v, b, ref_sbox(b));
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) send(1'b0, 8'($urandom));
   endtask

   // Monitor: expected valid is the in_valid seen at the edge; bytes come from the queue.
   always @(posedge clk) begin
      mon_iv  = in_valid;
      mon_rst = rst;
      #1;
      if (mon_rst || rst) begin
         check("rst_valid", int'(out_valid), 0);
         check("rst_byte", int'(out_byte), 0);
         exp_q.delete();
         held = 8'h00;
      end else begin
         check("valid", int'(out_valid), int'(mon_iv));
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 1, 0);
            end else begin
               held = exp_q.pop_front();
               check("sbox", int'(out_byte), int'(held));
            end
         end else begin
            check("hold", int'(out_byte), int'(held));
         end
      end
   end

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_byte  = 8'h00;
      held     = 8'h00;

      // Reset held with inputs toggling.
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         in_valid = 1'($urandom);
         in_byte  = 8'($urandom);
      end
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      idle(3);

      // Known vectors.
      send_exp(1'b1, 8'h00, 8'h63);
      send_exp(1'b1, 8'h01, 8'h7C);
      send_exp(1'b1, 8'h10, 8'hCA);
      send_exp(1'b1, 8'h53, 8'hED);
      send_exp(1'b1, 8'hFF, 8'h16);
      send_exp(1'b1, 8'hC9, 8'hDD);
      idle(2);

      // Gap: output must hold 7C while idle.
      send_exp(1'b1, 8'h01, 8'h7C);
      idle(2);
      send_exp(1'b1, 8'h53, 8'hED);
      idle(1);

      // Exhaustive back-to-back sweep.
      for (int b = 0; b < 256; b++) send(1'b1, 8'(b));
      idle(2);

      // Random stream with random gaps.
      for (int k = 0; k < 300; k++) send(1'($urandom_range(0, 3) != 0), 8'($urandom));

      // Asynchronous reset between edges with a result in flight.
      send(1'b1, 8'($urandom));
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid", int'(out_valid), 0);
      check("async_rst_byte", int'(out_byte), 0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         in_valid = 1'($urandom);
         in_byte  = 8'($urandom);
      end
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      idle(2);
      send_exp(1'b1, 8'h10, 8'hCA);
      for (int k = 0; k < 40; k++) send(1'b1, 8'($urandom));
      idle(3);

      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
